// File: rtl/mul_pkg.sv
// mul_pkg: shared types and constants for the sequential shift-and-add multiplier.
//   state_e    : controller state encoding (IDLE, WORK)
//   MUL_WIDTH  : default operand width
//   cnt_width(): width of the iteration counter for a given operand width
package mul_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WORK = 1'b1
  } state_e;

  localparam int unsigned MUL_WIDTH = 8;

  // The counter must hold values 0..WIDTH, so it needs clog2(WIDTH+1) bits.
  function automatic int unsigned cnt_width(int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/mul_shift_add_dp.sv
// mul_shift_add_dp: datapath of the shift-and-add multiplier.
//   Holds the multiplicand shift register (widened to 2*WIDTH), the multiplier
//   shift register, the 2*WIDTH accumulator and the iteration counter.
// Ports:
//   clk_i   in   clock
//   rst_i   in   asynchronous active-low reset, clears every register
//   load_i  in   capture a_i/b_i, clear accumulator and counter
//   step_i  in   perform one partial-product iteration
//   a_i     in   multiplicand
//   b_i     in   multiplier
//   sum_o   out  accumulator value after the current iteration
//   last_o  out  the current iteration is the final one
// Configuration: MUL_EARLY_EXIT_EN makes last_o also assert when the remaining
//   multiplier bits after this iteration are all zero.
module mul_shift_add_dp
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH = MUL_WIDTH
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               load_i,
  input  logic               step_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic [2*WIDTH-1:0] sum_o,
  output logic               last_o
);

  localparam int unsigned       CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0]     LAST_CNT = CW'(WIDTH - 1);

  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  // Partial product is added only when the current multiplier LSB is set.
  assign sum_o = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
`ifdef MUL_EARLY_EXIT_EN
    last_o = (cnt_q == LAST_CNT) || ((mplier_q >> 1) == '0);
`else
    last_o = (cnt_q == LAST_CNT);
`endif
  end

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    if (load_i) begin
      mcand_d  = {{WIDTH{1'b0}}, a_i};
      mplier_d = b_i;
      acc_d    = '0;
      cnt_d    = '0;
    end else if (step_i) begin
      acc_d    = sum_o;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
    end
  end

  // NOTE: registers use non-blocking assignments so all flops update together
  // from values sampled before the edge.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/mul.sv
// mul: sequential unsigned multiplier, y = a * b, one partial product per clock.
//   Start is level-sampled in IDLE; busy_o stays high while the datapath iterates,
//   and y_bo holds the last completed product until the next completion or reset.
// Ports:
//   clk_i    in   clock, rising edge
//   rst_i    in   asynchronous active-low reset
//   a_bi     in   multiplicand (WIDTH)
//   b_bi     in   multiplier (WIDTH)
//   start_i  in   start request, ignored while busy
//   busy_o   out  operation in progress
//   y_bo     out  registered product (2*WIDTH)
// Configuration: MUL_EARLY_EXIT_EN ends an operation as soon as the remaining
//   multiplier bits are zero; the product is the same either way.
module mul
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH = MUL_WIDTH
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [WIDTH-1:0]   a_bi,
  input  logic [WIDTH-1:0]   b_bi,
  input  logic               start_i,
  output logic               busy_o,
  output logic [2*WIDTH-1:0] y_bo
);

  state_e             state_q, state_d;
  logic               busy_q, busy_d;
  logic [2*WIDTH-1:0] y_q, y_d;
  logic               load, step, last;
  logic [2*WIDTH-1:0] sum;

  mul_shift_add_dp #(
    .WIDTH (WIDTH)
  ) u_dp (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load_i (load),
    .step_i (step),
    .a_i    (a_bi),
    .b_i    (b_bi),
    .sum_o  (sum),
    .last_o (last)
  );

  // State register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_i) state_d = WORK;
      WORK:    if (last)    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / control logic. The final iteration's sum goes straight into y_bo,
  // so the product is valid on the same edge busy_o drops.
  always_comb begin
    load   = 1'b0;
    step   = 1'b0;
    busy_d = busy_q;
    y_d    = y_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          load   = 1'b1;
          busy_d = 1'b1;
        end
      end
      WORK: begin
        step = 1'b1;
        if (last) begin
          y_d    = sum;
          busy_d = 1'b0;
        end
      end
      default: busy_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      busy_q <= 1'b0;
      y_q    <= '0;
    end else begin
      busy_q <= busy_d;
      y_q    <= y_d;
    end
  end

  assign busy_o = busy_q;
  assign y_bo   = y_q;

endmodule

// File: tb/tb_mul.sv
// tb_mul: self-checking bench for mul. A transaction-level model (product by
// plain multiplication, completion after a computed number of cycles) is
// compared with the DUT on every falling edge, plus directed literal checks.
module tb_mul;

  localparam int unsigned W = 8;

  logic           clk;
  logic           rst_n;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           start;
  logic           busy;
  logic [2*W-1:0] y;

  int unsigned tests = 0;
  int unsigned fails = 0;

  mul #(.WIDTH(W)) dut (
    .clk_i   (clk),
    .rst_i   (rst_n),
    .a_bi    (a),
    .b_bi    (b),
    .start_i (start),
    .busy_o  (busy),
    .y_bo    (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Cycles from the start-sample edge to completion.
  function automatic int unsigned latency(input logic [W-1:0] bv);
`ifdef MUL_EARLY_EXIT_EN
    int unsigned n = 1;
    for (int i = 0; i < int'(W); i++) if (bv[i]) n = i + 1;
    return n;
`else
    return W;
`endif
  endfunction

  // Behavioural model: an operation is just "product a*b appears after N edges".
  logic           m_busy = 1'b0;
  logic [2*W-1:0] m_y    = '0;
  logic [2*W-1:0] m_res  = '0;
  int unsigned    m_rem  = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0;
      m_y    = '0;
      m_rem  = 0;
    end else if (m_busy) begin
      m_rem = m_rem - 1;
      if (m_rem == 0) begin
        m_busy = 1'b0;
        m_y    = m_res;
      end
    end else if (start) begin
      m_res  = (2*W)'(a) * (2*W)'(b);
      m_rem  = latency(b);
      m_busy = 1'b1;
    end
  end

  always @(negedge clk) begin
    check("busy_vs_model", 32'(busy), 32'(m_busy));
    check("y_vs_model", 32'(y), 32'(m_y));
  end

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv);
    @(negedge clk);
    a = av; b = bv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
  endtask

  initial begin
    int cnt;
    int hold;
    rst_n = 1'b1; a = '0; b = '0; start = 1'b0;
    #2 rst_n = 1'b0;

    // Reset behaviour.
    repeat (2) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_y", 32'(y), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_y", 32'(y), 32'd0);

    // Squares sweep.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      a = W'(i); b = W'(i); start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (24) @(negedge clk);
      check("square", 32'(y), 32'(i * i));
    end
    check("square_15_literal", 32'(y), 32'd225);

    // Latency and busy width for 3*5.
    @(negedge clk);
    a = 8'd3; b = 8'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt = 0;
    while (busy && cnt < 50) begin
      cnt++;
      @(negedge clk);
    end
`ifdef MUL_EARLY_EXIT_EN
    check("busy_cycles_3x5", 32'(cnt), 32'd3);
`else
    check("busy_cycles_3x5", 32'(cnt), 32'd8);
`endif
    check("y_3x5", 32'(y), 32'd15);
    repeat (5) @(negedge clk);
    check("y_3x5_held", 32'(y), 32'd15);

    // Corners.
    do_op(8'd0, 8'd200);   check("y_0x200", 32'(y), 32'd0);
    do_op(8'd255, 8'd255); check("y_255x255", 32'(y), 32'd65025);
    do_op(8'd255, 8'd1);   check("y_255x1", 32'(y), 32'd255);
    do_op(8'd1, 8'd128);   check("y_1x128", 32'(y), 32'd128);

    // Start pulse while busy is ignored.
    @(negedge clk);
    a = 8'd7; b = 8'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 8'd2; b = 8'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    check("y_start_while_busy", 32'(y), 32'd63);
    repeat (12) @(negedge clk);
    check("no_second_run_busy", 32'(busy), 32'd0);
    check("no_second_run_y", 32'(y), 32'd63);

    // Reset mid-operation.
    @(negedge clk);
    a = 8'd10; b = 8'd10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset_busy", 32'(busy), 32'd0);
    check("midreset_y", 32'(y), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    do_op(8'd4, 8'd4);
    check("y_4x4_after_reset", 32'(y), 32'd16);

    // Randomized: operands, start held across completions, operand churn.
    for (int k = 0; k < 150; k++) begin
      @(negedge clk);
      a = W'($urandom);
      case ($urandom_range(0, 7))
        0:       b = '0;
        1:       b = '1;
        default: b = W'($urandom);
      endcase
      start = 1'b1;
      hold = int'($urandom_range(1, 12));
      repeat (hold) begin
        @(negedge clk);
        if ($urandom_range(0, 1) == 1) begin
          a = W'($urandom);
          b = W'($urandom);
        end
      end
      start = 1'b0;
      repeat ($urandom_range(0, 10)) @(negedge clk);
    end
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
